// File: rtl/ras_predecode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ras_predecode
// Desc   : Classifies fetched RV32 instructions as call / return / swap, issues
//          return-address-stack push/pop and forwards predictions to decode.
// Rev    : 1.0 - initial release
// ============================================================================
module ras_predecode #(
  parameter int WIDTH = 32,
  parameter int ILEN  = 32
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [ILEN-1:0]  in_instr,
  input  logic             flush,
  output logic             ras_push,
  output logic             ras_pop,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  input  logic             ras_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [ILEN-1:0]  out_instr,
  output logic             out_is_ret,
  output logic [WIDTH-1:0] out_target,
  output logic             out_target_valid
);

  localparam logic [6:0]       c_op_jal   = 7'b1101111;
  localparam logic [6:0]       c_op_jalr  = 7'b1100111;
  localparam logic [WIDTH-1:0] c_pc_step  = WIDTH'(4);

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Decode of the incoming instruction
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [2:0] w_funct3;
  logic       w_rd_link;
  logic       w_rs1_link;
  logic       w_is_jal;
  logic       w_is_jalr;
  logic       w_push_cls;
  logic       w_pop_cls;

  always_comb begin
    w_opcode   = in_instr[6:0];
    w_rd       = in_instr[11:7];
    w_funct3   = in_instr[14:12];
    w_rs1      = in_instr[19:15];
    w_rd_link  = is_link(w_rd);
    w_rs1_link = is_link(w_rs1);
    w_is_jal   = (w_opcode == c_op_jal);
    w_is_jalr  = (w_opcode == c_op_jalr) && (w_funct3 == 3'b000);
    w_push_cls = (w_is_jal || w_is_jalr) && w_rd_link;
    // rd == rs1 with both link registers is a plain call, not a swap
    w_pop_cls  = w_is_jalr && w_rs1_link && (!w_rd_link || (w_rd != w_rs1));
  end

  // Stage A
  logic             r_a_valid;
  logic             r_a_new;
  logic [WIDTH-1:0] r_a_pc;
  logic [ILEN-1:0]  r_a_instr;
  logic             r_a_push;
  logic             r_a_pop;
  logic [WIDTH-1:0] r_a_target;
  logic             r_a_tv;

  // Stage B
  logic             r_b_valid;
  logic [WIDTH-1:0] r_b_pc;
  logic [ILEN-1:0]  r_b_instr;
  logic             r_b_is_ret;
  logic [WIDTH-1:0] r_b_target;
  logic             r_b_tv;

  logic             w_a_adv;
  logic             w_in_ready;
  logic             w_fire;
  logic [WIDTH-1:0] w_a_target;
  logic             w_a_tv;

  always_comb begin
    w_a_adv    = !r_b_valid || out_ready;
    w_in_ready = !flush && (!r_a_valid || w_a_adv);
    w_fire     = in_valid && w_in_ready;
    // ras_dout is only the pre-pop top during A's first cycle; afterwards use the captured copy
    w_a_target = (r_a_new && r_a_pop) ? ras_dout : r_a_target;
    w_a_tv     = r_a_new ? (r_a_pop && !ras_empty) : r_a_tv;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_a_valid  <= 1'b0;
      r_a_new    <= 1'b0;
      r_a_pc     <= '0;
      r_a_instr  <= '0;
      r_a_push   <= 1'b0;
      r_a_pop    <= 1'b0;
      r_a_target <= '0;
      r_a_tv     <= 1'b0;
    end else if (flush) begin
      r_a_valid  <= 1'b0;
      r_a_new    <= 1'b0;
    end else if (w_fire) begin
      r_a_valid  <= 1'b1;
      r_a_new    <= 1'b1;
      r_a_pc     <= in_pc;
      r_a_instr  <= in_instr;
      r_a_push   <= w_push_cls;
      r_a_pop    <= w_pop_cls;
    end else if (r_a_valid && w_a_adv) begin
      r_a_valid  <= 1'b0;
      r_a_new    <= 1'b0;
    end else begin
      r_a_new    <= 1'b0;
      r_a_target <= w_a_target;
      r_a_tv     <= w_a_tv;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_b_valid  <= 1'b0;
      r_b_pc     <= '0;
      r_b_instr  <= '0;
      r_b_is_ret <= 1'b0;
      r_b_target <= '0;
      r_b_tv     <= 1'b0;
    end else if (flush) begin
      r_b_valid  <= 1'b0;
    end else if (w_a_adv) begin
      r_b_valid  <= r_a_valid;
      if (r_a_valid) begin
        r_b_pc     <= r_a_pc;
        r_b_instr  <= r_a_instr;
        r_b_is_ret <= r_a_pop;
        r_b_target <= w_a_target;
        r_b_tv     <= w_a_tv;
      end
    end
  end

  // Stack ops are issued only in A's first cycle so a stall never repeats them
  assign ras_push         = r_a_new && r_a_push && !flush;
  assign ras_pop          = r_a_new && r_a_pop && !flush;
  assign ras_din          = r_a_pc + c_pc_step;
  assign in_ready         = w_in_ready;
  assign out_valid        = r_b_valid;
  assign out_pc           = r_b_pc;
  assign out_instr        = r_b_instr;
  assign out_is_ret       = r_b_is_ret;
  assign out_target       = r_b_target;
  assign out_target_valid = r_b_tv;

endmodule
`default_nettype wire

// File: tb/tb_ras_predecode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_ras_predecode
// Desc   : Self-checking bench for ras_predecode with a behavioural stack model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ras_predecode;

  localparam int WIDTH = 32;
  localparam int ILEN  = 32;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_pc;
  logic [ILEN-1:0]  in_instr;
  logic             flush;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_din;
  logic [WIDTH-1:0] ras_dout;
  logic             ras_empty;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [ILEN-1:0]  out_instr;
  logic             out_is_ret;
  logic [WIDTH-1:0] out_target;
  logic             out_target_valid;

  always #5 clk = ~clk;

  ras_predecode #(.WIDTH(WIDTH), .ILEN(ILEN)) dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_pc            (in_pc),
    .in_instr         (in_instr),
    .flush            (flush),
    .ras_push         (ras_push),
    .ras_pop          (ras_pop),
    .ras_din          (ras_din),
    .ras_dout         (ras_dout),
    .ras_empty        (ras_empty),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_instr        (out_instr),
    .out_is_ret       (out_is_ret),
    .out_target       (out_target),
    .out_target_valid (out_target_valid)
  );

  // Behavioural return-address stack driven by the DUT's push/pop
  logic [WIDTH-1:0] stk [0:15];
  logic [3:0]       sp;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) sp <= 4'd0;
    else if (ras_push && ras_pop) begin
      if (sp != 4'd0) stk[sp - 4'd1] <= ras_din;
      else begin stk[0] <= ras_din; sp <= 4'd1; end
    end else if (ras_push) begin
      stk[sp] <= ras_din;
      sp      <= sp + 4'd1;
    end else if (ras_pop && sp != 4'd0) sp <= sp - 4'd1;
  end

  assign ras_empty = (sp == 4'd0);
  assign ras_dout  = (sp != 4'd0) ? stk[sp - 4'd1] : '0;

  typedef struct {
    logic [WIDTH-1:0] pc;
    logic [ILEN-1:0]  instr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] target;
    logic             tv;
  } vec_t;

  typedef struct { vec_t v; int cyc; bit lat; } exp_out_t;
  typedef struct { logic push; logic pop; logic [WIDTH-1:0] din; } exp_op_t;

  exp_out_t out_q[$];
  exp_op_t  op_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    return {20'h0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [2:0] f3);
    return {12'h0, rs1, f3, rd, 7'b1100111};
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic push,
                              input logic pop, input logic [31:0] din, input logic [31:0] target,
                              input logic tv);
    vec_t v;
    v.pc = pc; v.instr = instr; v.push = push; v.pop = pop;
    v.din = din; v.target = target; v.tv = tv;
    return v;
  endfunction

  // Output and stack-op monitors
  always @(negedge clk) begin : mon
    exp_out_t eo;
    exp_op_t  ep;
    if (!rst_i) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: pc 0x%0h with nothing expected", out_pc);
        end else begin
          eo = out_q.pop_front();
          check("out_pc", out_pc, eo.v.pc);
          check("out_instr", out_instr, eo.v.instr);
          check("out_is_ret", out_is_ret, eo.v.pop);
          check("out_target_valid", out_target_valid, eo.v.tv);
          if (eo.v.tv) check("out_target", out_target, eo.v.target);
          if (eo.lat) check("latency", cyc - eo.cyc, 2);
        end
      end
      if (ras_push || ras_pop) begin
        n_checks++;
        if (op_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ras_op: push %0b pop %0b din 0x%0h", ras_push, ras_pop, ras_din);
        end else begin
          ep = op_q.pop_front();
          check("ras_push", ras_push, ep.push);
          check("ras_pop", ras_pop, ep.pop);
          if (ep.push) check("ras_din", ras_din, ep.din);
        end
      end
    end
  end

  task automatic send(input vec_t v, input bit lat, input bit enq);
    int       waited;
    exp_out_t eo;
    exp_op_t  ep;
    waited   = 0;
    in_valid = 1'b1;
    in_pc    = v.pc;
    in_instr = v.instr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: pc 0x%0h never accepted", v.pc);
        break;
      end
    end
    if (in_ready && enq) begin
      eo.v = v; eo.cyc = cyc; eo.lat = lat;
      out_q.push_back(eo);
      if (v.push || v.pop) begin
        ep.push = v.push; ep.pop = v.pop; ep.din = v.din;
        op_q.push_back(ep);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_q.size() != 0 || op_q.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drain_out_q", out_q.size(), 0);
    check("drain_op_q", op_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [14];
    vec_t vc, vr, vn;
    logic [31:0] addi;
    addi = 32'h00408093;

    tbl[0]  = mk(32'h100, enc_jal(5'd1),               1, 0, 32'h104, 32'h0,   0);
    tbl[1]  = mk(32'h200, enc_jalr(5'd0, 5'd1, 3'd0),  0, 1, 32'h0,   32'h104, 1);
    tbl[2]  = mk(32'h300, enc_jal(5'd0),               0, 0, 32'h0,   32'h0,   0);
    tbl[3]  = mk(32'h304, enc_jalr(5'd0, 5'd6, 3'd0),  0, 0, 32'h0,   32'h0,   0);
    tbl[4]  = mk(32'h308, enc_jalr(5'd0, 5'd5, 3'd0),  0, 1, 32'h0,   32'h0,   0);
    tbl[5]  = mk(32'h07C, enc_jal(5'd1),               1, 0, 32'h80,  32'h0,   0);
    tbl[6]  = mk(32'h040, enc_jalr(5'd1, 5'd5, 3'd0),  1, 1, 32'h44,  32'h80,  1);
    tbl[7]  = mk(32'h500, enc_jalr(5'd5, 5'd5, 3'd0),  1, 0, 32'h504, 32'h0,   0);
    tbl[8]  = mk(32'h600, enc_jalr(5'd5, 5'd1, 3'd0),  1, 1, 32'h604, 32'h504, 1);
    tbl[9]  = mk(32'h700, enc_jalr(5'd1, 5'd10, 3'd0), 1, 0, 32'h704, 32'h0,   0);
    tbl[10] = mk(32'h800, enc_jalr(5'd0, 5'd1, 3'd1),  0, 0, 32'h0,   32'h0,   0);
    tbl[11] = mk(32'h900, enc_jalr(5'd0, 5'd1, 3'd0),  0, 1, 32'h0,   32'h704, 1);
    tbl[12] = mk(32'hA00, addi,                        0, 0, 32'h0,   32'h0,   0);
    tbl[13] = mk(32'hFFFFFFFC, enc_jal(5'd5),          1, 0, 32'h0,   32'h0,   0);

    rst_i = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_ras_push", ras_push, 0);
    check("reset_ras_pop", ras_pop, 0);
    check("reset_out_is_ret", out_is_ret, 0);
    check("reset_out_tv", out_target_valid, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back stream at full throughput
    for (int i = 0; i < 14; i++) begin
      check("stream_in_ready", in_ready, 1);
      send(tbl[i], 1'b1, 1'b1);
    end
    drain();

    // Return held in A behind a stalled B
    vc = mk(32'h1000, enc_jal(5'd1),              1, 0, 32'h1004, 32'h0,    0);
    vr = mk(32'h2000, enc_jalr(5'd0, 5'd1, 3'd0), 0, 1, 32'h0,    32'h1004, 1);
    vn = mk(32'h3000, addi,                       0, 0, 32'h0,    32'h0,    0);
    out_ready = 1'b0;
    fork
      begin
        send(vc, 1'b0, 1'b1);
        send(vr, 1'b0, 1'b1);
        send(vn, 1'b0, 1'b1);
      end
      begin : stall_ctl
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!(out_valid && !in_ready) && n < 20);
        check("stall_reached", out_valid && !in_ready, 1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_pc", out_pc, 32'h1000);
          check("stall_out_instr", out_instr, vc.instr);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush in the cycle a call sits in A
    in_valid = 1'b1; in_pc = 32'h4000; in_instr = enc_jal(5'd1);
    check("flush_pre_in_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b1; in_pc = 32'h5000; in_instr = addi;
    @(negedge clk);
    check("flush_ras_push", ras_push, 0);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_after_push", ras_push, 0);
    repeat (2) @(negedge clk);
    check("flush_out_valid_later", out_valid, 0);
    @(posedge clk); #1;

    // Asynchronous reset between edges with work in flight
    out_ready = 1'b0;
    send(mk(32'h6000, enc_jal(5'd1), 1, 0, 32'h6004, 32'h0, 0), 1'b0, 1'b1);
    in_valid = 1'b1; in_pc = 32'h7000; in_instr = enc_jal(5'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 check("prereset_ras_push", ras_push, 1);
    check("prereset_out_valid", out_valid, 1);
    #1 rst_i = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_ras_push", ras_push, 0);
    check("async_rst_ras_pop", ras_pop, 0);
    out_q.delete();
    op_q.delete();
    @(posedge clk); #1;
    rst_i = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(mk(32'h8000, enc_jal(5'd1), 1, 0, 32'h8004, 32'h0, 0), 1'b1, 1'b1);
    send(mk(32'h9000, enc_jalr(5'd0, 5'd1, 3'd0), 0, 1, 32'h0, 32'h8004, 1), 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
